instruction_fetch: RTL and testbench

Fetch-side counterpart to the instruction ROM. Owns the program counter and drives the 8-bit ROM address. Latches the 9-bit instruction that comes back into an instruction register for the decode stage. Handles stall, taken branch/jump redirect with a one-cycle squash, halt detection and restart.

---
 rtl/instruction_fetch.sv | 142 ++++++++++++++
 tb/tb_instruction_fetch.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: owns the program counter, addresses the combinational
// instruction ROM and latches the returned 9-bit word for decode.
// Handles stall, branch redirect with a one-bubble squash, halt on a halt
// opcode or an external request, and restart via start.
// Optional macro FETCH_COUNT_EN adds a saturating 16-bit fetch counter output.
module instruction_fetch #(
    parameter logic [7:0] RESET_PC    = 8'd0,
    parameter logic [3:0] HALT_OPCODE = 4'b1111
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [7:0]  branch_target,
    input  logic        halt_req,
    output logic [7:0]  rom_address,
    input  logic [8:0]  rom_instruction,
    output logic [8:0]  instr_out,
    output logic        instr_valid,
    output logic [7:0]  instr_pc,
    output logic        done
`ifdef FETCH_COUNT_EN
    ,
    output logic [15:0] fetch_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_HALTED
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [8:0]  instr_q, instr_d;
    logic [7:0]  ipc_q, ipc_d;
    logic        valid_q, valid_d;
    logic        done_q, done_d;
    logic        is_halt_op;
`ifdef FETCH_COUNT_EN
    logic [15:0] count_q, count_d;
`endif

    // The ROM answers combinationally, so the address is simply the PC.
    assign rom_address = pc_q;
    assign instr_out   = instr_q;
    assign instr_valid = valid_q;
    assign instr_pc    = ipc_q;
    assign done        = done_q;
`ifdef FETCH_COUNT_EN
    assign fetch_count = count_q;
`endif

    assign is_halt_op = (rom_instruction[8:5] == HALT_OPCODE);

    // Next-state and next-output computation; FETCH priority is
    // halt_req > branch_taken > stall > normal fetch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        valid_d = valid_q;
        done_d  = done_q;
`ifdef FETCH_COUNT_EN
        count_d = count_q;
`endif
        unique case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (start) begin
                    state_d = ST_FETCH;
                    pc_d    = RESET_PC;
                    valid_d = 1'b0;
                    done_d  = 1'b0;
`ifdef FETCH_COUNT_EN
                    count_d = '0;
`endif
                end else if (state_q == ST_HALTED) begin
                    // done rises on the first edge spent in HALTED.
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                end
            end
            ST_FETCH: begin
                if (halt_req) begin
                    state_d = ST_HALTED;
                    valid_d = 1'b0;
                end else if (branch_taken) begin
                    // Squash the wrong-path word; instr_out keeps its value.
                    pc_d    = branch_target;
                    valid_d = 1'b0;
                end else if (!stall) begin
                    instr_d = rom_instruction;
                    ipc_d   = pc_q;
                    valid_d = 1'b1;
`ifdef FETCH_COUNT_EN
                    if (count_q != '1) begin
                        count_d = count_q + 16'd1;
                    end
`endif
                    // The halt word is delivered valid but the PC stays on it.
                    if (is_halt_op) begin
                        state_d = ST_HALTED;
                    end else begin
                        pc_d = pc_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs, asynchronously cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            ipc_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
`ifdef FETCH_COUNT_EN
            count_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
            done_q  <= done_d;
`ifdef FETCH_COUNT_EN
            count_q <= count_d;
`endif
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: a behavioural reference model
// compared every cycle, plus hand-computed expectations along the way.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [7:0]  branch_target = 8'h00;
    logic        halt_req = 1'b0;
    logic [7:0]  rom_address;
    logic [8:0]  rom_instruction;
    logic [8:0]  instr_out;
    logic        instr_valid;
    logic [7:0]  instr_pc;
    logic        done;
`ifdef FETCH_COUNT_EN
    logic [15:0] fetch_count;
`endif

    int total = 0;
    int bad   = 0;

    logic [8:0] rom [256];

    instruction_fetch #(.RESET_PC(8'd0), .HALT_OPCODE(4'b1111)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .halt_req       (halt_req),
        .rom_address    (rom_address),
        .rom_instruction(rom_instruction),
        .instr_out      (instr_out),
        .instr_valid    (instr_valid),
        .instr_pc       (instr_pc),
        .done           (done)
`ifdef FETCH_COUNT_EN
        ,
        .fetch_count    (fetch_count)
`endif
    );

    always #5 clk = ~clk;

    assign rom_instruction = rom[rom_address];

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = {1'b0, 8'(i)};
        rom[7] = 9'b1111_00000;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: running/halted flags plus the architectural values.
    bit         m_run = 0, m_halted = 0;
    logic [7:0] m_pc = 8'h00, m_ipc = 8'h00;
    logic [8:0] m_instr = 9'h000;
    logic       m_valid = 0, m_done = 0;
    int         m_count = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 0; m_halted = 0; m_pc = 8'h00; m_ipc = 8'h00;
            m_instr = 9'h000; m_valid = 0; m_done = 0; m_count = 0;
        end else if (!m_run) begin
            if (start) begin
                m_run = 1; m_halted = 0; m_pc = 8'h00;
                m_valid = 0; m_done = 0; m_count = 0;
            end else if (m_halted) begin
                m_valid = 0; m_done = 1;
            end
        end else if (halt_req) begin
            m_run = 0; m_halted = 1; m_valid = 0;
        end else if (branch_taken) begin
            m_pc = branch_target; m_valid = 0;
        end else if (!stall) begin
            m_instr = rom[m_pc];
            m_ipc   = m_pc;
            m_valid = 1;
            if (m_count < 65535) m_count = m_count + 1;
            if (m_instr[8:5] == 4'b1111) begin
                m_run = 0; m_halted = 1;
            end else begin
                m_pc = (m_pc + 8'd1) & 8'hFF;
            end
        end
    end

    // Compare process, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_rom_address", rom_address, m_pc);
            chk("m_instr_valid", instr_valid, m_valid);
            chk("m_instr_out", instr_out, m_instr);
            chk("m_instr_pc", instr_pc, m_ipc);
            chk("m_done", done, m_done);
`ifdef FETCH_COUNT_EN
            chk("m_fetch_count", fetch_count, m_count);
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        repeat (2) cyc();
        chk("rst_addr", rom_address, 8'h00);
        chk("rst_valid", instr_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_instr", instr_out, 9'h000);
        chk("rst_ipc", instr_pc, 8'h00);
        rst_n = 1'b1;
        cyc();

        // Start and sequential fetch of words 0..3.
        start = 1'b1; cyc(); start = 1'b0;
        chk("start_valid", instr_valid, 0);
        chk("start_addr", rom_address, 8'h00);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("seq_ipc", instr_pc, i);
            chk("seq_instr", instr_out, i);
            chk("seq_valid", instr_valid, 1);
        end
        cyc();

        // Stall for three cycles at pc=5.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_addr", rom_address, 8'h05);
            chk("stall_ipc", instr_pc, 8'h04);
            chk("stall_instr", instr_out, 9'h004);
        end
        stall = 1'b0;
        cyc();
        chk("resume_ipc", instr_pc, 8'h05);
        chk("resume_addr", rom_address, 8'h06);

        // Branch redirect, without and with a simultaneous stall.
        for (int s = 0; s < 2; s++) begin
            branch_taken = 1'b1; branch_target = 8'h20; stall = (s == 1);
            cyc();
            branch_taken = 1'b0; stall = 1'b0;
            chk("br_valid", instr_valid, 0);
            chk("br_addr", rom_address, 8'h20);
            cyc();
            chk("br_ipc", instr_pc, 8'h20);
            chk("br_instr", instr_out, 9'h020);
            chk("br_valid2", instr_valid, 1);
        end

        // Halt opcode at address 7.
        branch_taken = 1'b1; branch_target = 8'h07; cyc(); branch_taken = 1'b0;
        cyc();
        chk("hop_instr", instr_out, 9'h1E0);
        chk("hop_ipc", instr_pc, 8'h07);
        chk("hop_valid", instr_valid, 1);
        chk("hop_addr", rom_address, 8'h07);
        cyc();
        chk("halted_valid", instr_valid, 0);
        chk("halted_done", done, 1);
        chk("halted_addr", rom_address, 8'h07);
        stall = 1'b1; branch_taken = 1'b1; branch_target = 8'h55; halt_req = 1'b1;
        cyc();
        stall = 1'b0; branch_taken = 1'b0; halt_req = 1'b0;
        chk("halted_frozen", rom_address, 8'h07);
        chk("halted_done2", done, 1);
        start = 1'b1; cyc(); start = 1'b0;
        chk("restart_addr", rom_address, 8'h00);
        chk("restart_done", done, 0);

        // Wrap FE, FF, 00 with start held high (ignored in FETCH).
        branch_taken = 1'b1; branch_target = 8'hFE; cyc(); branch_taken = 1'b0;
        start = 1'b1;
        cyc(); chk("wrap_ipc0", instr_pc, 8'hFE);
        cyc(); chk("wrap_ipc1", instr_pc, 8'hFF);
        cyc(); chk("wrap_ipc2", instr_pc, 8'h00);
        start = 1'b0;
        chk("wrap_addr", rom_address, 8'h01);

        // External halt request.
        halt_req = 1'b1; cyc(); halt_req = 1'b0;
        chk("hreq_valid", instr_valid, 0);
        chk("hreq_addr", rom_address, 8'h01);
        chk("hreq_done0", done, 0);
        cyc();
        chk("hreq_done1", done, 1);

        // Asynchronous reset mid-fetch at pc=0x13.
        start = 1'b1; cyc(); start = 1'b0;
        branch_taken = 1'b1; branch_target = 8'h10; cyc(); branch_taken = 1'b0;
        repeat (3) cyc();
        chk("pre_rst_addr", rom_address, 8'h13);
        rst_n = 1'b0;
        #1;
        chk("arst_addr", rom_address, 8'h00);
        chk("arst_valid", instr_valid, 0);
        chk("arst_instr", instr_out, 9'h000);
        chk("arst_ipc", instr_pc, 8'h00);
        chk("arst_done", done, 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("idle_valid", instr_valid, 0);
        chk("idle_addr", rom_address, 8'h00);

`ifdef FETCH_COUNT_EN
        // Ten fetches and two stalls from 0x40.
        start = 1'b1; cyc(); start = 1'b0;
        branch_taken = 1'b1; branch_target = 8'h40; cyc(); branch_taken = 1'b0;
        for (int i = 0; i < 12; i++) begin
            stall = (i == 3 || i == 7);
            cyc();
        end
        stall = 1'b0;
        chk("cnt_10", fetch_count, 16'd10);
        chk("cnt_ipc", instr_pc, 8'h49);
        rst_n = 1'b0;
        #1;
        chk("cnt_rst", fetch_count, 16'd0);
        cyc();
        rst_n = 1'b1;
`endif

        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
